// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream serializer: FSM encodings and counter sizing.
// The PARITY state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    // Bit-counter width: enough to count 0..w-1, and never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Bundle of the piso_stream load/serial-out signals.
// master = word producer/stream consumer side; slave = the serializer side.
interface piso_stream_if #(
    parameter int WIDTH = 8
);
    // Handshake: a word is accepted on a rising edge where load=1 and ready=1.
    // Each cycle with valid=1 carries one frame bit on dout; last marks the final bit.
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             dout;
    logic             valid;
    logic             last;

    modport master (
        output load,
        output din,
        input  ready,
        input  dout,
        input  valid,
        input  last
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output dout,
        output valid,
        output last
    );
endinterface

// File: rtl/piso_shreg.sv
// Loadable shift register; head is the bit currently presented to the serial output.
// MSB_FIRST selects which end is the head and therefore the shift direction.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             head
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            // Zeros fill in behind the head, so a drained register reads as 0.
            if (MSB_FIRST != 0) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign head = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer: FSM, bit counter and flags around a piso_shreg datapath.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic             READY,
    output logic             DOUT,
    output logic             VALID,
    output logic             LAST,
    output logic [1:0]       DBG_STATE
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          load_sr;
    logic          shift_sr;
    logic          last_data;
    logic          head;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_sr   = 1'b0;
        shift_sr  = 1'b0;
        last_data = (state_q == ST_SHIFT) && (cnt_q == CNT_MAX);
        VALID     = (state_q != ST_IDLE);
`ifdef PISO_PARITY_EN
        LAST      = (state_q == ST_PARITY);
        DOUT      = (state_q == ST_PARITY) ? par_q : (VALID & head);
`else
        LAST      = last_data;
        DOUT      = VALID & head;
`endif
        // READY during the final bit lets the next word follow with no gap.
        READY     = (state_q == ST_IDLE) || LAST;
        accept    = READY && LOAD;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                shift_sr = 1'b1;
                if (!last_data) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d  = ST_SHIFT;
            cnt_d    = '0;
            load_sr  = 1'b1;
            shift_sr = 1'b0;
        end
    end

`ifdef PISO_PARITY_EN
    assign par_d = load_sr ? ^DIN : par_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign DBG_STATE = state_q;

    piso_shreg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk  (CLK),
        .rst  (RST),
        .load (load_sr),
        .shift(shift_sr),
        .din  (DIN),
        .head (head)
    );

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream (WIDTH=4): MSB-first and LSB-first instances driven in lockstep,
// each checked cycle by cycle against its own expected-bit queue.
module tb_piso_stream;
    import piso_pkg::*;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 4 + PAR;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] din;
    logic [1:0] st_m, st_l;

    int tests_run = 0;
    int fails     = 0;

    // Entry: [2]=last, [1]=dout, [0]=parity-bit marker
    logic [2:0] exp_m[$];
    logic [2:0] exp_l[$];

    piso_stream_if #(.WIDTH(4)) ifm ();
    piso_stream_if #(.WIDTH(4)) ifl ();

    assign ifm.load = load;
    assign ifm.din  = din;
    assign ifl.load = load;
    assign ifl.din  = din;

    piso_stream #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .CLK(clk), .RST(rst), .LOAD(ifm.load), .DIN(ifm.din),
        .READY(ifm.ready), .DOUT(ifm.dout), .VALID(ifm.valid), .LAST(ifm.last),
        .DBG_STATE(st_m)
    );

    piso_stream #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .CLK(clk), .RST(rst), .LOAD(ifl.load), .DIN(ifl.din),
        .READY(ifl.ready), .DOUT(ifl.dout), .VALID(ifl.valid), .LAST(ifl.last),
        .DBG_STATE(st_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_state(input logic [2:0] e);
`ifdef PISO_PARITY_EN
        if (e[0]) return 2'(ST_PARITY);
`endif
        return 2'(ST_SHIFT);
    endfunction

    task automatic push_frame(input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            logic lst;
            lst = (i == 3) && (PAR == 0);
            exp_m.push_back({lst, d[3-i], 1'b0});
            exp_l.push_back({lst, d[i], 1'b0});
        end
        if (PAR != 0) begin
            exp_m.push_back({1'b1, ^d, 1'b1});
            exp_l.push_back({1'b1, ^d, 1'b1});
        end
    endtask

    // Compared vector: {dout, valid, last, ready, state}
    task automatic cmp(input string tag, input logic [5:0] got, input logic [5:0] expv);
        tests_run++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s observed={dout,valid,last,ready,st}=%b expected=%b", tag, got, expv);
        end
    endtask

    task automatic check_out(input string tag);
        logic [2:0] e;
        logic [5:0] expv;
        if (exp_m.size() > 0) begin
            e = exp_m.pop_front();
            expv = {e[1], 1'b1, e[2], e[2], exp_state(e)};
        end else begin
            expv = {1'b0, 1'b0, 1'b0, 1'b1, 2'(ST_IDLE)};
        end
        cmp({tag, "_msb"}, {ifm.dout, ifm.valid, ifm.last, ifm.ready, st_m}, expv);
        if (exp_l.size() > 0) begin
            e = exp_l.pop_front();
            expv = {e[1], 1'b1, e[2], e[2], exp_state(e)};
        end else begin
            expv = {1'b0, 1'b0, 1'b0, 1'b1, 2'(ST_IDLE)};
        end
        cmp({tag, "_lsb"}, {ifl.dout, ifl.valid, ifl.last, ifl.ready, st_l}, expv);
    endtask

    task automatic load_word(input logic [3:0] d);
        din  = d;
        load = 1'b1;
        push_frame(d);
        tick();
        load = 1'b0;
    endtask

    // Checks the remaining n bits of a frame, advancing one clock after each.
    task automatic check_bits(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_out(tag);
            tick();
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        din  = 4'b0000;
        tick();
        tick();
        check_out("reset");
        rst = 1'b0;
        tick();
        check_out("idle_after_reset");

        // Single frame 1011
        load_word(4'b1011);
        check_bits("frame_1011", FL);
        check_out("idle_after_1011");

        // Back-to-back: next LOAD on the LAST edge
        load_word(4'b1011);
        check_bits("b2b_first", FL - 1);
        check_out("b2b_last");
        din  = 4'b1100;
        load = 1'b1;
        push_frame(4'b1100);
        tick();
        load = 1'b0;
        check_bits("b2b_second", FL);
        check_out("idle_after_b2b");

        // LOAD while busy is ignored; DIN changes do not disturb the frame
        load_word(4'b1011);
        check_out("busy_bit0");
        tick();
        din  = 4'b0000;
        load = 1'b1;
        check_out("busy_bit1");
        tick();
        load = 1'b0;
        din  = 4'b1111;
        check_bits("busy_rest", FL - 2);
        check_out("idle_after_busy");
        tick();
        check_out("idle_hold");

        // Reset mid-frame, with LOAD asserted on the reset edge
        load_word(4'b1011);
        check_out("rst_bit0");
        tick();
        check_out("rst_bit1");
        rst  = 1'b1;
        load = 1'b1;
        din  = 4'b1111;
        exp_m.delete();
        exp_l.delete();
        tick();
        rst  = 1'b0;
        load = 1'b0;
        check_out("after_mid_rst");
        load_word(4'b0110);
        check_bits("frame_0110", FL);
        check_out("idle_after_0110");

        // Random words, alternating idle gaps and back-to-back loads
        for (int k = 0; k < 6; k++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            load_word(d);
            check_bits("rand_head", FL - 1);
            check_out("rand_last");
            if (k % 2 == 0) begin
                d = 4'($urandom_range(0, 15));
                din  = d;
                load = 1'b1;
                push_frame(d);
                tick();
                load = 1'b0;
                check_bits("rand_b2b", FL);
            end else begin
                tick();
            end
            check_out("rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
